// File: rtl/mini_alu_pkg.sv
// ----------------------------------------------------------------------------
// mini_alu_pkg
// Shared definitions for the mini ALU command path: the ALU opcode encoding,
// the scheduler state encoding and a helper that classifies opcodes.
// No ports (package).
// ----------------------------------------------------------------------------
package mini_alu_pkg;

  // ALU opcode encoding. 0x00 is the ALU's default/idle opcode and is
  // never a legal command.
  localparam logic [7:0] OP_IDLE = 8'h00;
  localparam logic [7:0] OP_ADD  = 8'h01;
  localparam logic [7:0] OP_SUB  = 8'h02;
  localparam logic [7:0] OP_MUL  = 8'h03;
  localparam logic [7:0] OP_DIV  = 8'h04;
  localparam logic [7:0] OP_AND  = 8'h05;
  localparam logic [7:0] OP_OR   = 8'h06;
  localparam logic [7:0] OP_XOR  = 8'h07;
  localparam logic [7:0] OP_NOT  = 8'h08;
  localparam logic [7:0] OP_SHL  = 8'h09;
  localparam logic [7:0] OP_SHR  = 8'h0A;
  localparam logic [7:0] OP_ROL  = 8'h0B;
  localparam logic [7:0] OP_ROR  = 8'h0C;
  localparam logic [7:0] OP_INC  = 8'h0D;
  localparam logic [7:0] OP_DEC  = 8'h0E;
  localparam logic [7:0] OP_CMP  = 8'h0F;

  // Scheduler states.
  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ISSUE    = 3'd1,
    ST_CAPTURE  = 3'd2,
    ST_WAIT_DIV = 3'd3,
    ST_RESP     = 3'd4
  } sched_state_t;

  // Legal commands occupy the contiguous range ADD..CMP.
  function automatic logic is_legal_op(input logic [7:0] op);
    return (op >= OP_ADD) && (op <= OP_CMP);
  endfunction

endpackage

// File: rtl/mini_alu_rr_arb.sv
// ----------------------------------------------------------------------------
// mini_alu_rr_arb
// Two-way round-robin arbiter. When both requesters are valid the one that
// was not granted last time wins; a single valid requester always wins.
// The history register only moves when the grant is actually consumed.
//
// Ports:
//   clk       in   clock
//   rst       in   asynchronous active-low reset
//   i_valid   in   [1:0] request valid per requester
//   i_accept  in   the current grant was consumed by a handshake
//   o_grant   out  index of the granted requester (meaningful only when the
//                  corresponding i_valid bit is set)
// ----------------------------------------------------------------------------
module mini_alu_rr_arb (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] i_valid,
  input  logic       i_accept,
  output logic       o_grant
);

  logic r_last_grant;
  logic w_grant;

  always_comb begin
    w_grant = 1'b0;
    case (i_valid)
      2'b11:   w_grant = ~r_last_grant;
      2'b10:   w_grant = 1'b1;
      default: w_grant = 1'b0;
    endcase
  end

  // Resetting to 1 makes requester 0 win the first tie.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_last_grant <= 1'b1;
    end else if (i_accept) begin
      r_last_grant <= w_grant;
    end
  end

  assign o_grant = w_grant;

endmodule

// File: rtl/mini_alu_cmd_sched.sv
// ----------------------------------------------------------------------------
// mini_alu_cmd_sched
// Command scheduler in front of the 16-bit mini ALU. Accepts commands from
// two requesters (round-robin), issues one at a time to the ALU, sequences
// single-cycle opcodes and the multi-cycle DIV (start pulse, completion wait,
// timeout), and returns each result on a valid/ready response channel tagged
// with the requester id.
//
// Ports:
//   clk, rst                         clock / asynchronous active-low reset
//   i_reqN_valid / o_reqN_ready      command handshake, N = 0,1
//   i_reqN_op/_a/_b/_shift           command opcode, operands, shift amount
//   o_alu_op/_data0/_data1/_num_shift registered ALU command outputs
//   o_alu_div_start                  one-cycle DIV start pulse
//   i_alu_result/_overflow/_valid    registered ALU results
//   o_rsp_valid / i_rsp_ready        response handshake
//   o_rsp_id/_result/_overflow/_err  response payload
// ----------------------------------------------------------------------------
module mini_alu_cmd_sched
  import mini_alu_pkg::*;
#(
  parameter int DIV_TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,

  input  logic        i_req0_valid,
  output logic        o_req0_ready,
  input  logic [7:0]  i_req0_op,
  input  logic [15:0] i_req0_a,
  input  logic [15:0] i_req0_b,
  input  logic [4:0]  i_req0_shift,

  input  logic        i_req1_valid,
  output logic        o_req1_ready,
  input  logic [7:0]  i_req1_op,
  input  logic [15:0] i_req1_a,
  input  logic [15:0] i_req1_b,
  input  logic [4:0]  i_req1_shift,

  output logic [7:0]  o_alu_op,
  output logic [15:0] o_alu_data0,
  output logic [15:0] o_alu_data1,
  output logic [4:0]  o_alu_num_shift,
  output logic        o_alu_div_start,
  input  logic [31:0] i_alu_result,
  input  logic        i_alu_overflow,
  input  logic        i_alu_valid,

  output logic        o_rsp_valid,
  input  logic        i_rsp_ready,
  output logic        o_rsp_id,
  output logic [31:0] o_rsp_result,
  output logic        o_rsp_overflow,
  output logic        o_rsp_err
);

  localparam int CNT_W = $clog2(DIV_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(DIV_TIMEOUT - 1);

  sched_state_t r_state;
  sched_state_t w_state_nxt;

  // Latched command
  logic [7:0]  r_op;
  logic [15:0] r_a;
  logic [15:0] r_b;
  logic [4:0]  r_shift;
  logic        r_id;

  // Registered ALU command outputs
  logic [7:0]  r_alu_op;
  logic [15:0] r_alu_data0;
  logic [15:0] r_alu_data1;
  logic [4:0]  r_alu_shift;
  logic        r_alu_div_start;

  // Response registers
  logic [31:0] r_rsp_result;
  logic        r_rsp_overflow;
  logic        r_rsp_err;

  logic [CNT_W-1:0] r_tmo_cnt;

  logic        w_grant;
  logic        w_idle;
  logic        w_accept;
  logic [7:0]  w_req_op;
  logic [15:0] w_req_a;
  logic [15:0] w_req_b;
  logic [4:0]  w_req_shift;
  logic [7:0]  w_cmd_op;
  logic [15:0] w_cmd_a;
  logic [15:0] w_cmd_b;
  logic [4:0]  w_cmd_shift;
  logic        w_drive_alu;
  logic        w_div_done;
  logic        w_div_tmo;

  mini_alu_rr_arb u_arb (
    .clk      (clk),
    .rst      (rst),
    .i_valid  ({i_req1_valid, i_req0_valid}),
    .i_accept (w_accept),
    .o_grant  (w_grant)
  );

  // A command is only taken in IDLE, from whichever requester holds the grant.
  assign w_idle       = (r_state == ST_IDLE);
  assign w_accept     = w_idle && (w_grant ? i_req1_valid : i_req0_valid);
  assign o_req0_ready = w_accept && !w_grant;
  assign o_req1_ready = w_accept && w_grant;

  always_comb begin
    w_req_op    = i_req0_op;
    w_req_a     = i_req0_a;
    w_req_b     = i_req0_b;
    w_req_shift = i_req0_shift;
    if (w_grant) begin
      w_req_op    = i_req1_op;
      w_req_a     = i_req1_a;
      w_req_b     = i_req1_b;
      w_req_shift = i_req1_shift;
    end
  end

  // The ALU registers load on the same edge as the command latch, so in IDLE
  // they take the incoming request directly rather than the latch contents.
  always_comb begin
    w_cmd_op    = r_op;
    w_cmd_a     = r_a;
    w_cmd_b     = r_b;
    w_cmd_shift = r_shift;
    if (w_idle) begin
      w_cmd_op    = w_req_op;
      w_cmd_a     = w_req_a;
      w_cmd_b     = w_req_b;
      w_cmd_shift = w_req_shift;
    end
  end

  // alu_valid in the first WAIT_DIV cycle still reflects the previous
  // operation, so completion is only recognised from the second cycle on.
  // A completion in the last allowed cycle wins over the timeout.
  assign w_div_done = (r_state == ST_WAIT_DIV) && (r_tmo_cnt != '0) && i_alu_valid;
  assign w_div_tmo  = (r_state == ST_WAIT_DIV) && !w_div_done && (r_tmo_cnt == TMO_LAST);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_state_nxt = is_legal_op(w_req_op) ? ST_ISSUE : ST_RESP;
        end
      end
      ST_ISSUE: begin
        w_state_nxt = (r_op == OP_DIV) ? ST_WAIT_DIV : ST_CAPTURE;
      end
      ST_CAPTURE: begin
        w_state_nxt = ST_RESP;
      end
      ST_WAIT_DIV: begin
        if (w_div_done || w_div_tmo) begin
          w_state_nxt = ST_RESP;
        end
      end
      ST_RESP: begin
        if (i_rsp_ready) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign w_drive_alu = (w_state_nxt == ST_ISSUE) ||
                       (w_state_nxt == ST_CAPTURE) ||
                       (w_state_nxt == ST_WAIT_DIV);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_op    <= OP_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_shift <= '0;
      r_id    <= 1'b0;
    end else if (w_accept) begin
      r_op    <= w_req_op;
      r_a     <= w_req_a;
      r_b     <= w_req_b;
      r_shift <= w_req_shift;
      r_id    <= w_grant;
    end
  end

  // The ALU sees the command only while it is being executed; otherwise it
  // is parked on the idle opcode with zero operands.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_alu_op        <= OP_IDLE;
      r_alu_data0     <= '0;
      r_alu_data1     <= '0;
      r_alu_shift     <= '0;
      r_alu_div_start <= 1'b0;
    end else begin
      r_alu_op        <= w_drive_alu ? w_cmd_op    : OP_IDLE;
      r_alu_data0     <= w_drive_alu ? w_cmd_a     : 16'h0000;
      r_alu_data1     <= w_drive_alu ? w_cmd_b     : 16'h0000;
      r_alu_shift     <= w_drive_alu ? w_cmd_shift : 5'd0;
      r_alu_div_start <= (w_state_nxt == ST_ISSUE) && (w_cmd_op == OP_DIV);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_tmo_cnt <= '0;
    end else if (r_state == ST_WAIT_DIV) begin
      r_tmo_cnt <= r_tmo_cnt + CNT_W'(1);
    end else begin
      r_tmo_cnt <= '0;
    end
  end

  // Illegal opcodes and DIV timeouts both report result 0 with overflow set.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rsp_result   <= '0;
      r_rsp_overflow <= 1'b0;
      r_rsp_err      <= 1'b0;
    end else if (w_accept && !is_legal_op(w_req_op)) begin
      r_rsp_result   <= '0;
      r_rsp_overflow <= 1'b1;
      r_rsp_err      <= 1'b1;
    end else if (r_state == ST_CAPTURE) begin
      r_rsp_result   <= i_alu_result;
      r_rsp_overflow <= i_alu_overflow;
      r_rsp_err      <= ~i_alu_valid;
    end else if (w_div_done) begin
      r_rsp_result   <= i_alu_result;
      r_rsp_overflow <= i_alu_overflow;
      r_rsp_err      <= 1'b0;
    end else if (w_div_tmo) begin
      r_rsp_result   <= '0;
      r_rsp_overflow <= 1'b1;
      r_rsp_err      <= 1'b1;
    end
  end

  assign o_alu_op        = r_alu_op;
  assign o_alu_data0     = r_alu_data0;
  assign o_alu_data1     = r_alu_data1;
  assign o_alu_num_shift = r_alu_shift;
  assign o_alu_div_start = r_alu_div_start;

  assign o_rsp_valid    = (r_state == ST_RESP);
  assign o_rsp_id       = r_id;
  assign o_rsp_result   = r_rsp_result;
  assign o_rsp_overflow = r_rsp_overflow;
  assign o_rsp_err      = r_rsp_err;

endmodule

// File: tb/tb_mini_alu_cmd_sched.sv
// ----------------------------------------------------------------------------
// tb_mini_alu_cmd_sched
// Self-checking bench for mini_alu_cmd_sched with a small behavioural ALU.
// The ALU model registers its result one edge after seeing a command; for
// DIV it leaves the previous alu_valid visible for one cycle, then drops it
// and raises it with {quotient, remainder} three edges after div_start
// (never, when aluStuck is set).
// ----------------------------------------------------------------------------
module tb_mini_alu_cmd_sched;

  logic        clk;
  logic        rst;
  logic        req0Valid, req1Valid;
  logic        req0Ready, req1Ready;
  logic [7:0]  req0Op, req1Op;
  logic [15:0] req0A, req0B, req1A, req1B;
  logic [4:0]  req0Shift, req1Shift;
  logic [7:0]  aluOp;
  logic [15:0] aluData0, aluData1;
  logic [4:0]  aluShift;
  logic        aluDivStart;
  logic [31:0] mResult;
  logic        mOvf, mValid;
  logic        rspValid, rspReady, rspId, rspOvf, rspErr;
  logic [31:0] rspResult;
  logic        aluStuck;
  logic [1:0]  divCnt;

  int checks = 0;
  int passes = 0;

  mini_alu_cmd_sched #(.DIV_TIMEOUT(8)) dut (
    .clk             (clk),
    .rst             (rst),
    .i_req0_valid    (req0Valid),
    .o_req0_ready    (req0Ready),
    .i_req0_op       (req0Op),
    .i_req0_a        (req0A),
    .i_req0_b        (req0B),
    .i_req0_shift    (req0Shift),
    .i_req1_valid    (req1Valid),
    .o_req1_ready    (req1Ready),
    .i_req1_op       (req1Op),
    .i_req1_a        (req1A),
    .i_req1_b        (req1B),
    .i_req1_shift    (req1Shift),
    .o_alu_op        (aluOp),
    .o_alu_data0     (aluData0),
    .o_alu_data1     (aluData1),
    .o_alu_num_shift (aluShift),
    .o_alu_div_start (aluDivStart),
    .i_alu_result    (mResult),
    .i_alu_overflow  (mOvf),
    .i_alu_valid     (mValid),
    .o_rsp_valid     (rspValid),
    .i_rsp_ready     (rspReady),
    .o_rsp_id        (rspId),
    .o_rsp_result    (rspResult),
    .o_rsp_overflow  (rspOvf),
    .o_rsp_err       (rspErr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ALU model
  logic [16:0] mSum;
  logic [16:0] mDiff;
  logic [31:0] mProd;
  assign mSum  = {1'b0, aluData0} + {1'b0, aluData1};
  assign mDiff = {1'b0, aluData0} - {1'b0, aluData1};
  assign mProd = 32'(aluData0) * 32'(aluData1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      divCnt  <= 2'd0;
      mValid  <= 1'b0;
      mResult <= 32'h0;
      mOvf    <= 1'b0;
    end else if (aluDivStart) begin
      divCnt <= 2'd3;
    end else if (divCnt != 2'd0) begin
      divCnt <= divCnt - 2'd1;
      if (divCnt == 2'd1 && !aluStuck && aluData1 != 16'h0) begin
        mResult <= {aluData0 / aluData1, aluData0 % aluData1};
        mOvf    <= 1'b0;
        mValid  <= 1'b1;
      end else begin
        mValid <= 1'b0;
      end
    end else if (aluOp != 8'h00 && aluOp != 8'h04) begin
      mValid <= 1'b1;
      case (aluOp)
        8'h01: begin mResult <= {16'h0, mSum[15:0]};  mOvf <= mSum[16];  end
        8'h02: begin mResult <= {16'h0, mDiff[15:0]}; mOvf <= mDiff[16]; end
        8'h03: begin mResult <= mProd;                mOvf <= 1'b0;      end
        default: begin mResult <= {aluData1, aluData0}; mOvf <= 1'b0;    end
      endcase
    end
  end

  typedef struct {
    bit          id;
    logic [7:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [4:0]  sh;
    logic [31:0] expResult;
    logic        expOvf;
    logic        expErr;
    int          expLat;
  } vec_t;

  vec_t vecs[8];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) begin
      passes++;
    end else begin
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Presents a command on one requester, waits (bounded) for its handshake,
  // and returns at the falling edge of the first cycle after the handshake.
  task automatic applyStimulus(input bit id, input logic [7:0] op, input logic [15:0] a,
                               input logic [15:0] b, input logic [4:0] sh);
    int n;
    @(negedge clk);
    if (id) begin
      req1Op = op; req1A = a; req1B = b; req1Shift = sh; req1Valid = 1'b1;
    end else begin
      req0Op = op; req0A = a; req0B = b; req0Shift = sh; req0Valid = 1'b1;
    end
    #1;
    n = 0;
    while (!(id ? req1Ready : req0Ready) && n < 20) begin
      @(negedge clk); #1; n++;
    end
    if (!(id ? req1Ready : req0Ready)) checkOutput("handshakeTimeout", 32'd0, 32'd1);
    @(posedge clk);
    @(negedge clk);
    req0Valid = 1'b0;
    req1Valid = 1'b0;
    #1;
  endtask

  // Samples once per cycle until rsp_valid, collecting ALU-side observations.
  task automatic waitResponse(output int lat, output int divPulses, output int divWaits,
                              output int aluBusy, output logic [7:0] fOp,
                              output logic [15:0] fA, output logic [15:0] fB,
                              output logic [4:0] fSh);
    bit done;
    done = 1'b0; divPulses = 0; divWaits = 0; aluBusy = 0; lat = -1;
    fOp = aluOp; fA = aluData0; fB = aluData1; fSh = aluShift;
    for (int i = 1; i <= 40; i++) begin
      if (aluDivStart) divPulses++;
      if (aluOp == 8'h04 && !aluDivStart) divWaits++;
      if (aluOp != 8'h00) aluBusy++;
      if (rspValid) begin
        lat = i;
        done = 1'b1;
        break;
      end
      @(negedge clk); #1;
    end
    if (!done) checkOutput("rspTimeout", 32'd0, 32'd1);
  endtask

  // Accepts the pending response; no command may be taken while in RESP.
  task automatic consumeResponse();
    rspReady = 1'b1;
    #1;
    checkOutput("noBypassReady", {30'd0, req1Ready, req0Ready}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    rspReady = 1'b0;
    #1;
  endtask

  initial begin
    int lat, pulses, waits, busy, n;
    logic [7:0]  fOp;
    logic [15:0] fA, fB;
    logic [4:0]  fSh;

    vecs[0] = '{1'b0, 8'h01, 16'h0003, 16'h0004, 5'd0,  32'h0000_0007, 1'b0, 1'b0, 3};
    vecs[1] = '{1'b1, 8'h01, 16'hFFFF, 16'h0001, 5'd3,  32'h0000_0000, 1'b1, 1'b0, 3};
    vecs[2] = '{1'b0, 8'h02, 16'h0010, 16'h0020, 5'd31, 32'h0000_FFF0, 1'b1, 1'b0, 3};
    vecs[3] = '{1'b1, 8'h03, 16'h1234, 16'h0100, 5'd7,  32'h0012_3400, 1'b0, 1'b0, 3};
    vecs[4] = '{1'b0, 8'h20, 16'h1111, 16'h2222, 5'd1,  32'h0000_0000, 1'b1, 1'b1, 1};
    vecs[5] = '{1'b1, 8'h00, 16'h0005, 16'h0006, 5'd2,  32'h0000_0000, 1'b1, 1'b1, 1};
    vecs[6] = '{1'b0, 8'h10, 16'h0007, 16'h0008, 5'd4,  32'h0000_0000, 1'b1, 1'b1, 1};
    vecs[7] = '{1'b1, 8'h0F, 16'h1234, 16'hABCD, 5'd16, 32'hABCD_1234, 1'b0, 1'b0, 3};

    rst = 1'b0; rspReady = 1'b0; aluStuck = 1'b0;
    req0Valid = 1'b0; req0Op = 8'h00; req0A = 16'h0; req0B = 16'h0; req0Shift = 5'd0;
    req1Valid = 1'b0; req1Op = 8'h00; req1A = 16'h0; req1B = 16'h0; req1Shift = 5'd0;

    // Reset values
    repeat (3) @(negedge clk);
    #1;
    checkOutput("resetAluCtl", {18'd0, aluOp, aluShift, aluDivStart}, 32'd0);
    checkOutput("resetAluData", {aluData0, aluData1}, 32'd0);
    checkOutput("resetRspCtl", {26'd0, rspValid, rspId, rspOvf, rspErr, req0Ready, req1Ready}, 32'd0);
    checkOutput("resetRspResult", rspResult, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk); #1;
    checkOutput("idleNoReady", {30'd0, req1Ready, req0Ready}, 32'd0);

    // Tie and alternation: both requesters continuously valid with MUL
    req0Op = 8'h03; req0A = 16'h0010; req0B = 16'h0010; req0Shift = 5'd0; req0Valid = 1'b1;
    req1Op = 8'h03; req1A = 16'h0010; req1B = 16'h0010; req1Shift = 5'd0; req1Valid = 1'b1;
    #1;
    for (int k = 0; k < 4; k++) begin
      n = 0;
      while (!(req0Ready || req1Ready) && n < 20) begin
        @(negedge clk); #1; n++;
      end
      checkOutput($sformatf("tie%0dOneReady", k), 32'(req0Ready) + 32'(req1Ready), 32'd1);
      checkOutput($sformatf("tie%0dGrant", k), {31'd0, req1Ready}, 32'(k % 2));
      @(posedge clk);
      @(negedge clk); #1;
      waitResponse(lat, pulses, waits, busy, fOp, fA, fB, fSh);
      checkOutput($sformatf("tie%0dLatency", k), 32'(lat), 32'd3);
      checkOutput($sformatf("tie%0dResult", k), rspResult, 32'h0000_0100);
      checkOutput($sformatf("tie%0dId", k), {31'd0, rspId}, 32'(k % 2));
      consumeResponse();
    end
    req0Valid = 1'b0;
    req1Valid = 1'b0;

    // Table-driven single commands
    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i].id, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].sh);
      waitResponse(lat, pulses, waits, busy, fOp, fA, fB, fSh);
      checkOutput($sformatf("vec%0dLatency", i), 32'(lat), 32'(vecs[i].expLat));
      checkOutput($sformatf("vec%0dResult", i), rspResult, vecs[i].expResult);
      checkOutput($sformatf("vec%0dOvf", i), {31'd0, rspOvf}, {31'd0, vecs[i].expOvf});
      checkOutput($sformatf("vec%0dErr", i), {31'd0, rspErr}, {31'd0, vecs[i].expErr});
      checkOutput($sformatf("vec%0dId", i), {31'd0, rspId}, {31'd0, vecs[i].id});
      if (vecs[i].expErr) begin
        checkOutput($sformatf("vec%0dAluIdle", i), 32'(busy), 32'd0);
      end else begin
        checkOutput($sformatf("vec%0dIssueOp", i), {24'd0, fOp}, {24'd0, vecs[i].op});
        checkOutput($sformatf("vec%0dIssueAB", i), {fA, fB}, {vecs[i].a, vecs[i].b});
        checkOutput($sformatf("vec%0dIssueShift", i), {27'd0, fSh}, {27'd0, vecs[i].sh});
      end
      consumeResponse();
    end

    // DIV on req1: stale alu_valid in the first wait cycle must be ignored
    applyStimulus(1'b1, 8'h04, 16'd100, 16'd7, 5'd0);
    waitResponse(lat, pulses, waits, busy, fOp, fA, fB, fSh);
    checkOutput("divStartPulses", 32'(pulses), 32'd1);
    checkOutput("divWaitCycles", 32'(waits), 32'd4);
    checkOutput("divResult", rspResult, {16'd14, 16'd2});
    checkOutput("divFlags", {29'd0, rspId, rspOvf, rspErr}, 32'b100);
    consumeResponse();

    // DIV timeout: ALU never completes
    aluStuck = 1'b1;
    applyStimulus(1'b0, 8'h04, 16'd50, 16'd5, 5'd0);
    waitResponse(lat, pulses, waits, busy, fOp, fA, fB, fSh);
    checkOutput("tmoWaitCycles", 32'(waits), 32'd8);
    checkOutput("tmoResult", rspResult, 32'd0);
    checkOutput("tmoFlags", {29'd0, rspId, rspOvf, rspErr}, 32'b011);
    consumeResponse();
    aluStuck = 1'b0;

    // Illegal opcode followed by 5 cycles of backpressure
    applyStimulus(1'b0, 8'h20, 16'h0001, 16'h0002, 5'd0);
    waitResponse(lat, pulses, waits, busy, fOp, fA, fB, fSh);
    checkOutput("bpLatency", 32'(lat), 32'd1);
    req1Op = 8'h01; req1A = 16'h0001; req1B = 16'h0001; req1Valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      #1;
      checkOutput($sformatf("bpHold%0dCtl", c),
                  {26'd0, rspValid, rspErr, rspOvf, rspId, req0Ready, req1Ready}, 32'b111000);
      checkOutput($sformatf("bpHold%0dData", c), rspResult | {24'd0, aluOp}, 32'd0);
      @(negedge clk);
    end
    #1;
    consumeResponse();
    checkOutput("bpReadyAfterResp", {31'd0, req1Ready}, 32'd1);
    req1Valid = 1'b0;

    // Reset during WAIT_DIV
    applyStimulus(1'b0, 8'h04, 16'd9, 16'd3, 5'd0);
    n = 0;
    while (!(aluOp == 8'h04 && !aluDivStart) && n < 20) begin
      @(negedge clk); #1; n++;
    end
    checkOutput("midResetInWait", {24'd0, aluOp}, 32'h04);
    rst = 1'b0;
    #1;
    checkOutput("midResetAluCtl", {18'd0, aluOp, aluShift, aluDivStart}, 32'd0);
    checkOutput("midResetAluData", {aluData0, aluData1}, 32'd0);
    checkOutput("midResetRspCtl", {26'd0, rspValid, rspId, rspOvf, rspErr, req0Ready, req1Ready}, 32'd0);
    checkOutput("midResetRspResult", rspResult, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    req0Op = 8'h01; req0A = 16'h0001; req0B = 16'h0001; req0Valid = 1'b1;
    req1Op = 8'h01; req1A = 16'h0001; req1B = 16'h0001; req1Valid = 1'b1;
    #1;
    checkOutput("postResetTieGrant", {30'd0, req1Ready, req0Ready}, 32'b01);
    @(posedge clk);
    @(negedge clk);
    req0Valid = 1'b0;
    req1Valid = 1'b0;
    #1;
    waitResponse(lat, pulses, waits, busy, fOp, fA, fB, fSh);
    checkOutput("postResetLatency", 32'(lat), 32'd3);
    checkOutput("postResetResult", rspResult, 32'd2);
    checkOutput("postResetId", {31'd0, rspId}, 32'd0);
    consumeResponse();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
